// File: rtl/result_ram_write_controller.sv
// Accepts result rows from the multiply core, buffers them in a small FIFO and
// writes them into the result BRAM, one matrix of ROWS rows per mode.
module result_ram_write_controller #(
  parameter int DATA_W     = 1024,
  parameter int ADDR_W     = 7,
  parameter int ROWS       = 32,
  parameter int NUM_MODES  = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              row_valid,
  input  logic [DATA_W-1:0] row_data,
  input  logic              row_error,
  output logic              row_ready,
  output logic              wea_o,
  output logic [ADDR_W-1:0] addra_o,
  output logic [DATA_W-1:0] dina_o,
  output logic [1:0]        mode_idx,
  output logic              mode_done,
  output logic [5:0]        err_count,
  output logic              busy,
  output logic              finish
);

  localparam int TOTAL   = NUM_MODES * ROWS;
  localparam int RC_W    = $clog2(ROWS);
  localparam int IC_W    = $clog2(TOTAL + 1);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = DATA_W + 1;

  localparam logic [RC_W-1:0]  LAST_ROW  = RC_W'(ROWS - 1);
  localparam logic [1:0]       LAST_MODE = 2'(NUM_MODES - 1);
  localparam logic [IC_W-1:0]  LAST_IN   = IC_W'(TOTAL - 1);
  localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [5:0]       ERR_MAX   = 6'd63;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state_reg;
  logic [ENTRY_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_reg;
  logic [PTR_W-1:0]    rd_ptr_reg;
  logic [PTR_W:0]      count_reg;
  logic [RC_W-1:0]     row_cnt_reg;
  logic [IC_W-1:0]     in_cnt_reg;
  logic                last_written_reg;

  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic [ENTRY_W-1:0]  rd_entry;
  logic [ADDR_W-1:0]   wr_addr;

  assign fifo_full  = (count_reg == FULL_CNT);
  assign fifo_empty = (count_reg == '0);
  assign row_ready  = (state_reg == RUN) && !fifo_full;
  assign push       = row_valid && row_ready;
  assign pop        = !fifo_empty;
  assign rd_entry   = fifo_mem[rd_ptr_reg];
  assign wr_addr    = ADDR_W'(mode_idx) * ADDR_W'(ROWS) + ADDR_W'(row_cnt_reg);

  // Payload storage carries no reset so it maps onto plain RAM/LUT storage.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {row_error, row_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      row_cnt_reg      <= '0;
      in_cnt_reg       <= '0;
      last_written_reg <= 1'b0;
      wea_o            <= 1'b0;
      addra_o          <= '0;
      dina_o           <= '0;
      mode_idx         <= '0;
      mode_done        <= 1'b0;
      err_count        <= '0;
      busy             <= 1'b0;
      finish           <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (push && !pop) begin
        count_reg <= count_reg + 1'b1;
      end else if (pop && !push) begin
        count_reg <= count_reg - 1'b1;
      end

      // Write port: one BRAM write per popped entry, address from pop-side counters.
      mode_done <= 1'b0;
      if (pop) begin
        wea_o   <= 1'b1;
        addra_o <= wr_addr;
        dina_o  <= rd_entry[DATA_W-1:0];
        if (rd_entry[DATA_W] && (err_count != ERR_MAX)) begin
          err_count <= err_count + 6'd1;
        end
        if (row_cnt_reg == LAST_ROW) begin
          row_cnt_reg <= '0;
          mode_done   <= 1'b1;
          if (mode_idx != LAST_MODE) begin
            mode_idx <= mode_idx + 2'd1;
          end else begin
            last_written_reg <= 1'b1;
          end
        end else begin
          row_cnt_reg <= row_cnt_reg + 1'b1;
        end
      end else begin
        wea_o <= 1'b0;
      end

      finish <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg        <= RUN;
            busy             <= 1'b1;
            row_cnt_reg      <= '0;
            in_cnt_reg       <= '0;
            mode_idx         <= '0;
            err_count        <= '0;
            last_written_reg <= 1'b0;
          end
        end
        RUN: begin
          if (push) begin
            in_cnt_reg <= in_cnt_reg + 1'b1;
            if (in_cnt_reg == LAST_IN) begin
              state_reg <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // last_written_reg is set on the final pop, so this fires the cycle after the last write.
          if (fifo_empty && last_written_reg) begin
            state_reg <= DONE;
            finish    <= 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_ram_write_controller.sv
// Randomized bench for result_ram_write_controller: a row-level model predicts every
// BRAM write, handshake, pulse and counter value and a negedge process compares each cycle.
module tb_result_ram_write_controller;
  localparam int DATA_W    = 1024;
  localparam int ADDR_W    = 7;
  localparam int ROWS      = 32;
  localparam int NUM_MODES = 3;
  localparam int TOTAL     = NUM_MODES * ROWS;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              row_valid = 1'b0;
  logic [DATA_W-1:0] row_data = '0;
  logic              row_error = 1'b0;
  logic              row_ready;
  logic              wea_o;
  logic [ADDR_W-1:0] addra_o;
  logic [DATA_W-1:0] dina_o;
  logic [1:0]        mode_idx;
  logic              mode_done;
  logic [5:0]        err_count;
  logic              busy;
  logic              finish;

  always #5 clk = ~clk;

  result_ram_write_controller #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ROWS(ROWS), .NUM_MODES(NUM_MODES), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .row_valid(row_valid), .row_data(row_data),
    .row_error(row_error), .row_ready(row_ready), .wea_o(wea_o), .addra_o(addra_o),
    .dina_o(dina_o), .mode_idx(mode_idx), .mode_done(mode_done), .err_count(err_count),
    .busy(busy), .finish(finish)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  task automatic chk_data(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    int bad;
    checks++;
    if (act !== exp) begin
      errors++;
      bad = 0;
      for (int j = DATA_W/32 - 1; j >= 0; j--) begin
        if (act[j*32 +: 32] !== exp[j*32 +: 32]) bad = j;
      end
      $display("FAIL %s t=%0t word=%0d actual=%h required=%h", name, $time, bad,
               act[bad*32 +: 32], exp[bad*32 +: 32]);
    end
  endtask

  // Row-level model: every accepted row k becomes one write to address k two cycles later.
  typedef struct {
    int                due;
    int                addr;
    logic [DATA_W-1:0] data;
    logic              err;
  } wr_t;

  wr_t wq[$];
  wr_t w;
  int  cyc = 0;
  bit  m_busy = 0;
  int  acc = 0;
  int  err_tot = 0;
  int  exp_err = 0;
  int  exp_mode = 0;
  int  finish_due = -10;
  int  busy_end = -10;
  int  run_writes = 0;
  int  run_mdone = 0;
  bit  hs;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_wea", wea_o, 0);
      chk("rst_addr", addra_o, 0);
      chk_data("rst_dina", dina_o, '0);
      chk("rst_mode_idx", mode_idx, 0);
      chk("rst_mode_done", mode_done, 0);
      chk("rst_err_count", err_count, 0);
      chk("rst_busy", busy, 0);
      chk("rst_finish", finish, 0);
      chk("rst_row_ready", row_ready, 0);
      wq.delete();
      m_busy = 0; acc = 0; err_tot = 0; exp_err = 0; exp_mode = 0;
      finish_due = -10; busy_end = -10;
    end else begin
      if (wq.size() > 0 && wq[0].due == cyc) begin
        w = wq.pop_front();
        chk("wea", wea_o, 1);
        chk("addr", addra_o, 64'(w.addr));
        chk_data("dina", dina_o, w.data);
        chk("mode_done", mode_done, 64'((w.addr % ROWS) == ROWS - 1));
        if (w.err) err_tot++;
        exp_err  = (err_tot > 63) ? 63 : err_tot;
        exp_mode = ((w.addr + 1) / ROWS > NUM_MODES - 1) ? NUM_MODES - 1 : (w.addr + 1) / ROWS;
      end else begin
        chk("wea_idle", wea_o, 0);
        chk("mode_done_idle", mode_done, 0);
      end
      if (wea_o) run_writes++;
      if (mode_done) run_mdone++;
      chk("mode_idx", mode_idx, 64'(exp_mode));
      chk("err_count", err_count, 64'(exp_err));
      chk("busy", busy, 64'(m_busy));
      chk("finish", finish, 64'(cyc == finish_due));
      chk("row_ready", row_ready, 64'(m_busy && acc < TOTAL));

      hs = row_valid && m_busy && (acc < TOTAL);
      if (hs) begin
        wq.push_back('{due: cyc + 2, addr: acc, data: row_data, err: row_error});
        acc++;
        if (acc == TOTAL) begin
          finish_due = cyc + 3;
          busy_end   = cyc + 3;
        end
      end
      if (!m_busy && start) begin
        m_busy = 1; acc = 0; err_tot = 0; exp_err = 0; exp_mode = 0;
        run_writes = 0; run_mdone = 0; finish_due = -10; busy_end = -10;
      end else if (m_busy && busy_end >= 0 && cyc + 1 > busy_end) begin
        m_busy = 0;
      end
    end
    cyc++;
  end

  function automatic logic [DATA_W-1:0] gen_data(input int i, input int dmode);
    logic [31:0]       word;
    logic [DATA_W-1:0] d;
    word = i;
    d = {32{word}};
    if (dmode != 0) begin
      for (int j = 0; j < DATA_W/32; j++) d[j*32 +: 32] = $urandom;
    end
    return d;
  endfunction

  function automatic logic gen_err(input int i, input int emode);
    case (emode)
      1:       return (i == 5) || (i == 40) || (i == 90);
      2:       return i < 70;
      3:       return $urandom_range(0, 3) == 0;
      default: return 1'b0;
    endcase
  endfunction

  // Driver: called #1 after a rising edge; holds a row until it is accepted.
  task automatic send_rows(input int n, input int vmode, input int dmode, input int emode);
    int i = 0;
    int t = 0;
    bit took;
    while (i < n && t < 2000) begin
      if (!row_valid) begin
        row_data  = gen_data(i, dmode);
        row_error = gen_err(i, emode);
        case (vmode)
          1:       row_valid = (t % 3 == 0);
          2:       row_valid = $urandom_range(0, 1);
          default: row_valid = 1'b1;
        endcase
      end
      @(negedge clk);
      took = row_valid && row_ready;
      @(posedge clk); #1;
      if (took) begin
        i++;
        row_valid = 1'b0;
      end
      t++;
    end
    row_valid = 1'b0;
    if (i < n) chk("send_timeout", i, n);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int g = 0;
    while (busy && g < 300) begin
      @(posedge clk); #1;
      g++;
    end
    chk("busy_cleared", busy, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Rows offered while idle must be refused.
    row_valid = 1'b1;
    row_data  = gen_data(123, 0);
    repeat (5) @(posedge clk);
    #1 row_valid = 1'b0;

    // Back-to-back stream, rows 5/40/90 flagged, then a 97th row offered.
    do_start();
    send_rows(TOTAL, 0, 0, 1);
    row_valid = 1'b1;
    row_data  = gen_data(TOTAL, 0);
    repeat (5) @(posedge clk);
    #1 row_valid = 1'b0;
    wait_done();
    chk("runA_writes", run_writes, 96);
    chk("runA_mode_done", run_mdone, 3);
    chk("runA_err_count", err_count, 3);
    chk("runA_last_addr", addra_o, 95);
    chk("runA_last_mode", mode_idx, 2);

    // Random data and gaps, with a start pulse mid-run that must be ignored.
    do_start();
    send_rows(40, 0, 1, 0);
    do_start();
    send_rows(TOTAL - 40, 2, 1, 3);
    wait_done();
    chk("runB_writes", run_writes, 96);
    chk("runB_mode_done", run_mdone, 3);

    // 1-0-0 valid pattern with 70 flagged rows: count saturates.
    do_start();
    send_rows(TOTAL, 1, 0, 2);
    wait_done();
    chk("runC_writes", run_writes, 96);
    chk("runC_err_sat", err_count, 63);

    // Reset mid-run, then a fresh run must start again at address 0.
    do_start();
    send_rows(40, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_addr", addra_o, 0);
    chk("midrst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    do_start();
    send_rows(TOTAL, 2, 1, 3);
    wait_done();
    chk("runD_writes", run_writes, 96);
    chk("runD_mode_done", run_mdone, 3);
    chk("runD_last_addr", addra_o, 95);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
